// File: rtl/sr599_drv_if.sv
// Host handshake and downstream sn74ls599 pin bundle for sr599_drv.
interface sr599_drv_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load;
    logic             clr;
    logic             ready;
    logic             done;
    logic             ser;
    logic             sck;
    logic             rck;
    logic             sclr;
    logic             rclr;

    modport master (
        output din, load, clr,
        input  ready, done, ser, sck, rck, sclr, rclr
    );

    modport slave (
        input  din, load, clr,
        output ready, done, ser, sck, rck, sclr, rclr
    );
endinterface

// File: rtl/sr599_drv.sv
// Parallel-to-serial driver for cascaded sn74ls599 shift/output registers.
// Shifts a word out MSB first on ser/sck, then pulses rck once.
module sr599_drv #(
    parameter int WIDTH = 8,
    parameter int HALF  = 1
) (
    input  logic       clk,
    input  logic       rst,
    sr599_drv_if.slave bus
);
    localparam int CW = $clog2(HALF + 1);
    localparam int NW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] C_RLD  = CW'(HALF - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [NW-1:0] N_FULL = NW'(WIDTH);
    localparam logic [NW-1:0] N_ONE  = NW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SLO,
        S_SHI,
        S_LLO,
        S_LHI,
        S_CLEAR
    } state_t;

    state_t           r_state;
    state_t           w_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt;
    logic [NW-1:0]    r_n;
    logic [NW-1:0]    w_n;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] w_sh;
    logic             w_tick;

    logic r_ready, r_done, r_ser, r_sck, r_rck, r_sclr, r_rclr;
    logic w_ready, w_done, w_ser, w_sck, w_rck, w_sclr, w_rclr;

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_n     <= '0;
            r_sh    <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_ser   <= 1'b0;
            r_sck   <= 1'b0;
            r_rck   <= 1'b0;
            r_sclr  <= 1'b1;
            r_rclr  <= 1'b1;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_n     <= w_n;
            r_sh    <= w_sh;
            r_ready <= w_ready;
            r_done  <= w_done;
            r_ser   <= w_ser;
            r_sck   <= w_sck;
            r_rck   <= w_rck;
            r_sclr  <= w_sclr;
            r_rclr  <= w_rclr;
        end
    end

    // CLEAR reuses the bit counter to run its half-period timer twice
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt - C_ONE;
        w_n     = r_n;
        w_sh    = r_sh;
        unique case (r_state)
            S_IDLE: begin
                w_cnt = '0;
                if (bus.clr) begin
                    w_state = S_CLEAR;
                    w_cnt   = C_RLD;
                    w_n     = N_ONE;
                end else if (bus.load) begin
                    w_state = S_SLO;
                    w_cnt   = C_RLD;
                    w_n     = N_FULL;
                    w_sh    = bus.din;
                end
            end
            S_SLO: begin
                if (w_tick) begin
                    w_state = S_SHI;
                    w_cnt   = C_RLD;
                end
            end
            S_SHI: begin
                if (w_tick) begin
                    w_cnt   = C_RLD;
                    w_sh    = r_sh << 1;
                    w_n     = r_n - N_ONE;
                    w_state = (r_n == N_ONE) ? S_LLO : S_SLO;
                end
            end
            S_LLO: begin
                if (w_tick) begin
                    w_state = S_LHI;
                    w_cnt   = C_RLD;
                end
            end
            S_LHI: begin
                if (w_tick) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end
            end
            S_CLEAR: begin
                if (w_tick) begin
                    if (r_n == '0) begin
                        w_state = S_IDLE;
                        w_cnt   = '0;
                    end else begin
                        w_n   = r_n - N_ONE;
                        w_cnt = C_RLD;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the pins change with it
    always_comb begin
        w_ready = (w_state == S_IDLE);
        w_done  = (r_state == S_LHI) && (w_state == S_IDLE);
        w_ser   = 1'b0;
        w_sck   = (w_state == S_SHI);
        w_rck   = (w_state == S_LHI);
        w_sclr  = (w_state != S_CLEAR);
        w_rclr  = (w_state != S_CLEAR);
        if ((w_state == S_SLO) || (w_state == S_SHI)) begin
            w_ser = w_sh[WIDTH-1];
        end
    end

    assign bus.ready = r_ready;
    assign bus.done  = r_done;
    assign bus.ser   = r_ser;
    assign bus.sck   = r_sck;
    assign bus.rck   = r_rck;
    assign bus.sclr  = r_sclr;
    assign bus.rclr  = r_rclr;
endmodule

// File: tb/tb_sr599_drv.sv
// Bench for sr599_drv with behavioural sn74ls599 loads on three instances.
module tb_sr599_drv;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   fails  = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    sr599_drv_if #(.WIDTH(8))  b8 ();
    sr599_drv_if #(.WIDTH(8))  b3 ();
    sr599_drv_if #(.WIDTH(16)) b16 ();

    sr599_drv #(.WIDTH(8), .HALF(1)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );
    sr599_drv #(.WIDTH(8), .HALF(3)) u3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );
    sr599_drv #(.WIDTH(16), .HALF(1)) u16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    // sn74ls599 models: shift on sck rise, transfer on rck rise
    logic [7:0]  s8, q8, s3, q3;
    logic [15:0] s16, q16;

    always @(posedge b8.sck or negedge b8.sclr)
        if (!b8.sclr) s8 <= '0; else s8 <= {s8[6:0], b8.ser};
    always @(posedge b8.rck or negedge b8.rclr)
        if (!b8.rclr) q8 <= '0; else q8 <= s8;
    always @(posedge b3.sck or negedge b3.sclr)
        if (!b3.sclr) s3 <= '0; else s3 <= {s3[6:0], b3.ser};
    always @(posedge b3.rck or negedge b3.rclr)
        if (!b3.rclr) q3 <= '0; else q3 <= s3;
    always @(posedge b16.sck or negedge b16.sclr)
        if (!b16.sclr) s16 <= '0; else s16 <= {s16[14:0], b16.ser};
    always @(posedge b16.rck or negedge b16.rclr)
        if (!b16.rclr) q16 <= '0; else q16 <= s16;

    task automatic run8(input int pulse_at, output int cyc, output int nsck,
                        output int nrck, output logic [7:0] bits, output bit ok);
        logic ps, pr;
        cyc = 0; nsck = 0; nrck = 0; bits = '0; ok = 1'b1; ps = 1'b0; pr = 1'b0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == pulse_at) begin
                b8.din  = 8'hFF;
                b8.load = 1'b1;
            end else if (cyc == pulse_at + 1) begin
                b8.load = 1'b0;
            end
            if (b8.sck && !ps) begin
                nsck++;
                bits = {bits[6:0], b8.ser};
            end
            if (b8.rck && !pr) nrck++;
            if (b8.sck && b8.rck) ok = 1'b0;
            if (b8.done) return;
            if (b8.ready) ok = 1'b0;
            ps = b8.sck;
            pr = b8.rck;
        end
        cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({b8.ready, b8.done, b8.ser, b8.sck, b8.rck, b8.sclr, b8.rclr} !== 7'b1000011) begin
            fails++;
            $display("FAIL reset_w8 got=%b exp=1000011",
                     {b8.ready, b8.done, b8.ser, b8.sck, b8.rck, b8.sclr, b8.rclr});
        end
        checks++;
        if ({b3.ready, b3.done, b3.ser, b3.sck, b3.rck, b3.sclr, b3.rclr} !== 7'b1000011) begin
            fails++;
            $display("FAIL reset_h3 got=%b exp=1000011",
                     {b3.ready, b3.done, b3.ser, b3.sck, b3.rck, b3.sclr, b3.rclr});
        end
        checks++;
        if ({b16.ready, b16.done, b16.ser, b16.sck, b16.rck, b16.sclr, b16.rclr} !== 7'b1000011) begin
            fails++;
            $display("FAIL reset_w16 got=%b exp=1000011",
                     {b16.ready, b16.done, b16.ser, b16.sck, b16.rck, b16.sclr, b16.rclr});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b8.ready, b8.done, b8.ser, b8.sck, b8.rck, b8.sclr, b8.rclr} !== 7'b1000011) begin
            fails++;
            $display("FAIL idle_w8 got=%b exp=1000011",
                     {b8.ready, b8.done, b8.ser, b8.sck, b8.rck, b8.sclr, b8.rclr});
        end
    endtask

    task automatic test_frame_a5();
        int cyc, ns, nr;
        logic [7:0] bits;
        bit ok;
        logic [15:0] e;
        @(negedge clk);
        b8.din  = 8'hA5;
        b8.load = 1'b1;
        sb.push_back(16'h00A5);
        @(negedge clk);
        b8.load = 1'b0;
        b8.din  = 8'h00;
        run8(-1, cyc, ns, nr, bits, ok);
        checks++;
        if (cyc !== 18) begin fails++; $display("FAIL a5_done_cycle got=%0d exp=18", cyc); end
        checks++;
        if (ns !== 8) begin fails++; $display("FAIL a5_sck_pulses got=%0d exp=8", ns); end
        checks++;
        if (bits !== 8'hA5) begin fails++; $display("FAIL a5_ser_bits got=%h exp=a5", bits); end
        checks++;
        if (nr !== 1) begin fails++; $display("FAIL a5_rck_pulses got=%0d exp=1", nr); end
        checks++;
        if (ok !== 1'b1) begin fails++; $display("FAIL a5_busy_overlap got=%b exp=1", ok); end
        checks++;
        if (b8.ready !== 1'b1) begin fails++; $display("FAIL a5_ready_with_done got=%b exp=1", b8.ready); end
        e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        checks++;
        if (q8 !== e[7:0]) begin fails++; $display("FAIL a5_q got=%h exp=%h", q8, e[7:0]); end
        @(negedge clk);
        checks++;
        if (b8.done !== 1'b0) begin fails++; $display("FAIL a5_done_width got=%b exp=0", b8.done); end
    endtask

    task automatic test_clear_priority();
        int nlow, nsck, nd;
        nlow = 0; nsck = 0; nd = 0;
        @(negedge clk);
        b8.clr  = 1'b1;
        b8.load = 1'b1;
        b8.din  = 8'h3C;
        @(negedge clk);
        b8.clr  = 1'b0;
        b8.load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!b8.sclr && !b8.rclr) nlow++;
            if (b8.sck) nsck++;
            if (b8.done) nd++;
            @(negedge clk);
        end
        checks++;
        if (nlow !== 2) begin fails++; $display("FAIL clr_low_cycles got=%0d exp=2", nlow); end
        checks++;
        if (nsck !== 0) begin fails++; $display("FAIL clr_no_shift got=%0d exp=0", nsck); end
        checks++;
        if (nd !== 0) begin fails++; $display("FAIL clr_no_done got=%0d exp=0", nd); end
        checks++;
        if (q8 !== 8'h00) begin fails++; $display("FAIL clr_q got=%h exp=00", q8); end
        checks++;
        if (b8.ready !== 1'b1) begin fails++; $display("FAIL clr_ready got=%b exp=1", b8.ready); end
    endtask

    task automatic test_ignore_busy();
        int cyc, ns, nr;
        logic [7:0] bits;
        bit ok;
        logic [15:0] e;
        @(negedge clk);
        b8.din  = 8'h5A;
        b8.load = 1'b1;
        sb.push_back(16'h005A);
        @(negedge clk);
        b8.load = 1'b0;
        run8(5, cyc, ns, nr, bits, ok);
        checks++;
        if (cyc !== 18) begin fails++; $display("FAIL ign_done_cycle got=%0d exp=18", cyc); end
        checks++;
        if (bits !== 8'h5A) begin fails++; $display("FAIL ign_ser_bits got=%h exp=5a", bits); end
        e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        checks++;
        if (q8 !== e[7:0]) begin fails++; $display("FAIL ign_q got=%h exp=%h", q8, e[7:0]); end
        repeat (3) @(negedge clk);
        checks++;
        if (b8.ready !== 1'b1) begin fails++; $display("FAIL ign_no_queue got=%b exp=1", b8.ready); end
    endtask

    task automatic test_back_to_back();
        int cyc, d1, d2;
        logic [15:0] e;
        cyc = 0; d1 = -1; d2 = -1;
        @(negedge clk);
        b8.din  = 8'h11;
        b8.load = 1'b1;
        sb.push_back(16'h0011);
        sb.push_back(16'h0022);
        @(negedge clk);
        b8.din = 8'h22;
        while (cyc < 80 && d2 < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 19) b8.load = 1'b0;
            if (b8.done) begin
                if (d1 < 0) d1 = cyc; else d2 = cyc;
                e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
                checks++;
                if (q8 !== e[7:0]) begin
                    fails++;
                    $display("FAIL b2b_q got=%h exp=%h", q8, e[7:0]);
                end
            end
        end
        b8.load = 1'b0;
        checks++;
        if (d1 !== 18) begin fails++; $display("FAIL b2b_first_done got=%0d exp=18", d1); end
        checks++;
        if (d2 - d1 !== 19) begin fails++; $display("FAIL b2b_period got=%0d exp=19", d2 - d1); end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        @(negedge clk);
        b8.din  = 8'hFF;
        b8.load = 1'b1;
        @(negedge clk);
        b8.load = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (b8.sck) found = 1'b1;
        end
        checks++;
        if (found !== 1'b1) begin fails++; $display("FAIL rmid_reach_shi got=%b exp=1", found); end
        rst = 1'b1;
        #1;
        checks++;
        if ({b8.ready, b8.done, b8.ser, b8.sck, b8.rck, b8.sclr, b8.rclr} !== 7'b1000011) begin
            fails++;
            $display("FAIL rmid_async got=%b exp=1000011",
                     {b8.ready, b8.done, b8.ser, b8.sck, b8.rck, b8.sclr, b8.rclr});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        checks++;
        if (q8 !== 8'h22) begin fails++; $display("FAIL rmid_no_rck got=%h exp=22", q8); end
        checks++;
        if (b8.ready !== 1'b1) begin fails++; $display("FAIL rmid_idle got=%b exp=1", b8.ready); end
    endtask

    task automatic test_half3();
        int cyc, run, nsck;
        logic prev, sv;
        bit chg, got;
        logic [7:0] bits;
        logic [15:0] e;
        cyc = 0; nsck = 0; chg = 1'b0; got = 1'b0; bits = '0;
        @(negedge clk);
        b3.din  = 8'h81;
        b3.load = 1'b1;
        sb.push_back(16'h0081);
        @(negedge clk);
        b3.load = 1'b0;
        b3.din  = 8'h00;
        prev = b3.sck;
        sv   = b3.ser;
        run  = 1;
        while (cyc < 300 && !got) begin
            @(negedge clk);
            cyc++;
            if (b3.sck !== prev) begin
                checks++;
                if (run !== 3) begin
                    fails++;
                    $display("FAIL h3_phase_len sck_was=%b got=%0d exp=3", prev, run);
                end
                if (!prev) begin
                    nsck++;
                    bits = {bits[6:0], b3.ser};
                    checks++;
                    if (chg !== 1'b0) begin
                        fails++;
                        $display("FAIL h3_ser_setup got=%b exp=0", chg);
                    end
                end
                run = 1;
                chg = 1'b0;
                sv  = b3.ser;
            end else begin
                run++;
                if (b3.ser !== sv) chg = 1'b1;
            end
            prev = b3.sck;
            if (b3.done) got = 1'b1;
        end
        checks++;
        if (cyc !== 54) begin fails++; $display("FAIL h3_busy got=%0d exp=54", cyc); end
        checks++;
        if (nsck !== 8) begin fails++; $display("FAIL h3_sck_pulses got=%0d exp=8", nsck); end
        checks++;
        if (bits !== 8'h81) begin fails++; $display("FAIL h3_ser_bits got=%h exp=81", bits); end
        e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        checks++;
        if (q3 !== e[7:0]) begin fails++; $display("FAIL h3_q got=%h exp=%h", q3, e[7:0]); end
    endtask

    task automatic test_cascade();
        int cyc, nsck;
        logic ps;
        bit got;
        logic [15:0] e;
        cyc = 0; nsck = 0; ps = 1'b0; got = 1'b0;
        @(negedge clk);
        b16.din  = 16'h1234;
        b16.load = 1'b1;
        sb.push_back(16'h1234);
        @(negedge clk);
        b16.load = 1'b0;
        while (cyc < 200 && !got) begin
            @(negedge clk);
            cyc++;
            if (b16.sck && !ps) nsck++;
            ps = b16.sck;
            if (b16.done) got = 1'b1;
        end
        checks++;
        if (cyc !== 34) begin fails++; $display("FAIL w16_busy got=%0d exp=34", cyc); end
        checks++;
        if (nsck !== 16) begin fails++; $display("FAIL w16_sck_pulses got=%0d exp=16", nsck); end
        e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        checks++;
        if (q16[7:0] !== e[7:0]) begin
            fails++;
            $display("FAIL w16_dev1_q got=%h exp=%h", q16[7:0], e[7:0]);
        end
        checks++;
        if (q16[15:8] !== e[15:8]) begin
            fails++;
            $display("FAIL w16_dev2_q got=%h exp=%h", q16[15:8], e[15:8]);
        end
    endtask

    initial begin
        b8.din  = '0; b8.load  = 1'b0; b8.clr  = 1'b0;
        b3.din  = '0; b3.load  = 1'b0; b3.clr  = 1'b0;
        b16.din = '0; b16.load = 1'b0; b16.clr = 1'b0;
        test_reset();
        test_frame_a5();
        test_clear_priority();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_half3();
        test_cascade();
        checks++;
        if (sb.size() !== 0) begin
            fails++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
